// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with valid/ready handshake.
// A main entry (M) drives the outputs and a skid entry (S) sits behind it.
// Because of the skid entry, ready_o comes straight from a flop.
// Also provides synchronous flush with bubble insertion, and saturating
// stall/bubble performance counters.
module pipe_stage_buf #(
  parameter int                DATA_W      = 128,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter bit                CLEAR_DATA  = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       bubble_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_m_valid;
  logic              r_s_valid;
  logic              r_ready;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_s_data;
  logic [15:0]       r_stall_cnt;
  logic [15:0]       r_bubble_cnt;

  logic              w_up_xfer;
  logic              w_dn_xfer;
  logic              w_load_m_in;
  logic              w_load_m_skid;
  logic              w_load_s;
  logic              w_stall_evt;
  logic              w_bubble_evt;

  // ready is the registered flag, so the upstream handshake never sees
  // downstream ready/stall/flush combinationally.
  assign w_up_xfer    = start_i & valid_i & r_ready & ~flush_i;
  assign w_dn_xfer    = r_m_valid & ready_i & ~stall_i;
  assign w_stall_evt  = r_m_valid & ~w_dn_xfer & ~flush_i;
  assign w_bubble_evt = ~r_m_valid & start_i;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_EMPTY;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic; flush overrides the handshake
  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_up_xfer) w_state_next = ST_ONE;
        ST_ONE: begin
          if (w_up_xfer && !w_dn_xfer)      w_state_next = ST_FULL;
          else if (!w_up_xfer && w_dn_xfer) w_state_next = ST_EMPTY;
        end
        ST_FULL:  if (w_dn_xfer) w_state_next = ST_ONE;
        default:  w_state_next = ST_EMPTY;
      endcase
    end
  end

  // FSM outputs: load strobes for the main and skid entries
  always_comb begin
    w_load_m_in   = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s      = 1'b0;
    if (!flush_i) begin
      case (r_state)
        ST_EMPTY: w_load_m_in = w_up_xfer;
        ST_ONE: begin
          w_load_m_in = w_up_xfer & w_dn_xfer;
          w_load_s    = w_up_xfer & ~w_dn_xfer;
        end
        ST_FULL:  w_load_m_skid = w_dn_xfer;
        default: begin
          w_load_m_in   = 1'b0;
          w_load_m_skid = 1'b0;
          w_load_s      = 1'b0;
        end
      endcase
    end
  end

  // Valid bits and ready are registered decodes of the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_m_valid <= (w_state_next != ST_EMPTY);
      r_s_valid <= (w_state_next == ST_FULL);
      r_ready   <= (w_state_next != ST_FULL);
    end
  end

  // Main entry payload: data is kept on flush unless CLEAR_DATA is set
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_ctrl <= CTRL_BUBBLE;
      r_m_data <= '0;
    end else if (flush_i) begin
      if (CLEAR_DATA) r_m_data <= '0;
    end else if (w_load_m_in) begin
      r_m_ctrl <= ctrl_i;
      r_m_data <= data_i;
    end else if (w_load_m_skid) begin
      r_m_ctrl <= r_s_ctrl;
      r_m_data <= r_s_data;
    end
  end

  // Skid entry payload; only meaningful while the skid valid bit is set
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s_ctrl <= '0;
      r_s_data <= '0;
    end else if (w_load_s) begin
      r_s_ctrl <= ctrl_i;
      r_s_data <= data_i;
    end
  end

  // Saturating performance counters; flush does not clear them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_bubble_evt && (r_bubble_cnt != 16'hFFFF))
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign ready_o      = r_ready;
  assign valid_o      = r_m_valid;
  assign ctrl_o       = r_m_valid ? r_m_ctrl : CTRL_BUBBLE;
  assign data_o       = r_m_data;
  assign occupancy_o  = {1'b0, r_m_valid} + {1'b0, r_s_valid};
  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: two instances (CLEAR_DATA 0 and 1) share stimulus.
// A queue-based reference model predicts the outputs of each cycle and pushes
// every predicted downstream transfer into a scoreboard. A monitor drains the
// scoreboard whenever the DUT hands an entry downstream.
module tb_pipe_stage_buf;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam logic [CW-1:0] BUB = 8'hA5;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, start_i, valid_i, flush_i, stall_i, ready_i;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;

  logic          ready0, valid0, ready1, valid1;
  logic [CW-1:0] ctrl0, ctrl1;
  logic [DW-1:0] data0, data1;
  logic [1:0]    occ0, occ1;
  logic [15:0]   stall0, bub0, stall1, bub1;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CLEAR_DATA(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .ready_o(ready0),
    .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .stall_i(stall_i), .ready_i(ready_i),
    .valid_o(valid0), .ctrl_o(ctrl0), .data_o(data0), .occupancy_o(occ0),
    .stall_cnt_o(stall0), .bubble_cnt_o(bub0)
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CLEAR_DATA(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .ready_o(ready1),
    .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .stall_i(stall_i), .ready_i(ready_i),
    .valid_o(valid1), .ctrl_o(ctrl1), .data_o(data1), .occupancy_o(occ1),
    .stall_cnt_o(stall1), .bubble_cnt_o(bub1)
  );

  item_t       mq[$];     // entries held by the stage, oldest first
  item_t       exp_q[$];  // scoreboard of predicted downstream transfers
  int          checks = 0;
  int          errors = 0;
  bit          m_init = 1'b0;
  logic [15:0] m_stall, m_bubble;
  logic [DW-1:0] m_last0, m_last1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Reference model: check this cycle's outputs, then predict the next edge
  always @(negedge clk) begin
    int    n;
    bit    up, dn;
    item_t it;
    n = mq.size();
    if (m_init) begin
      chk("valid_o", 64'(valid0), 64'(n > 0));
      chk("ready_o", 64'(ready0), 64'(n < 2));
      chk("occupancy_o", 64'(occ0), 64'(n));
      chk("ctrl_o", 64'(ctrl0), 64'((n > 0) ? mq[0].c : BUB));
      chk("data_o", 64'(data0), 64'(m_last0));
      chk("stall_cnt_o", 64'(stall0), 64'(m_stall));
      chk("bubble_cnt_o", 64'(bub0), 64'(m_bubble));
      chk("valid_o_clr", 64'(valid1), 64'(n > 0));
      chk("data_o_clr", 64'(data1), 64'(m_last1));
    end
    if (rst_i) begin
      mq.delete();
      m_stall  = '0;
      m_bubble = '0;
      m_last0  = '0;
      m_last1  = '0;
      m_init   = 1'b1;
    end else if (m_init) begin
      up = start_i && valid_i && (n < 2) && !flush_i;
      dn = (n > 0) && ready_i && !stall_i;
      if (n == 0 && start_i) m_bubble = sat_inc(m_bubble);
      if (flush_i) begin
        mq.delete();
        m_last1 = '0;
      end else begin
        if (n > 0 && !dn) m_stall = sat_inc(m_stall);
        if (dn) exp_q.push_back(mq.pop_front());
        if (up) begin
          it = {ctrl_i, data_i};
          mq.push_back(it);
        end
        if (mq.size() > 0) begin
          m_last0 = mq[0].d;
          m_last1 = mq[0].d;
        end
      end
    end
  end

  // Monitor: whenever the DUT hands an entry downstream, pop and compare
  always begin
    item_t e;
    @(negedge clk);
    #1;
    if (m_init && valid0 && ready_i && !stall_i && !flush_i && !rst_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h required=none t=%0t", data0, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ctrl", 64'(ctrl0), 64'(e.c));
        chk("sb_data", 64'(data0), 64'(e.d));
      end
    end
  end

  task automatic step(input bit rs, input bit st, input bit v, input bit fl, input bit sl,
                      input bit rd, input logic [CW-1:0] c, input logic [DW-1:0] d);
    rst_i   = rs;
    start_i = st;
    valid_i = v;
    flush_i = fl;
    stall_i = sl;
    ready_i = rd;
    ctrl_i  = c;
    data_i  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    stall_i = 1'b0; ready_i = 1'b0; ctrl_i = '0; data_i = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 8'h00, 32'h0);
    step(1, 0, 0, 0, 0, 0, 8'h00, 32'h0);

    // streaming at full rate
    for (int i = 1; i <= 5; i++) step(0, 1, 1, 0, 0, 1, 8'(8'h10 + i), 32'(i));
    step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);
    step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);

    // back-pressure: three stalled cycles fill the skid entry
    step(0, 1, 1, 0, 0, 1, 8'h2A, 32'hA);
    step(0, 1, 1, 0, 1, 1, 8'h2B, 32'hB);
    step(0, 1, 1, 0, 1, 1, 8'h2C, 32'hC);
    step(0, 1, 1, 0, 1, 1, 8'h2C, 32'hC);
    step(0, 1, 1, 0, 0, 1, 8'h2C, 32'hC);
    step(0, 1, 1, 0, 0, 1, 8'h2C, 32'hC);
    step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);
    step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);

    // flush while FULL with a new entry offered in the same cycle
    step(0, 1, 1, 0, 1, 1, 8'h31, 32'h11);
    step(0, 1, 1, 0, 1, 1, 8'h32, 32'h12);
    step(0, 1, 1, 1, 1, 1, 8'h3D, 32'hD);
    step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);
    step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);

    // run enable low: nothing enters, bubble counter frozen
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 1, 8'h44, 32'h44);
    step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);
    step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);

    // flush with 0x55 held: zeroed only on the CLEAR_DATA instance
    step(0, 1, 1, 0, 1, 0, 8'h55, 32'h55);
    step(0, 1, 0, 0, 1, 0, 8'h00, 32'h0);
    step(0, 1, 0, 1, 0, 0, 8'h00, 32'h0);
    step(0, 1, 0, 0, 0, 0, 8'h00, 32'h0);
    step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0),
           8'($urandom), 32'($urandom));
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);

    // stall counter saturation, then reset clears the counters
    step(0, 1, 1, 0, 0, 0, 8'h77, 32'h77);
    for (int i = 0; i < 70000; i++) step(0, 1, 0, 0, 1, 1, 8'h00, 32'h0);
    step(1, 1, 0, 0, 1, 1, 8'h00, 32'h0);
    step(0, 1, 1, 0, 0, 1, 8'h78, 32'h78);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, 8'h00, 32'h0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register for the 5-stage RISC-V core. It succeeds the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB latches with one generic block that carries an opaque control bundle and an opaque data bundle. It adds:
- a valid/ready handshake,
- a 2-entry skid buffer, so upstream `ready_o` is fully registered,
- synchronous flush with bubble insertion,
- saturating stall and bubble performance counters.

## Interface

- `DATA_W`, default 128: width of the data bundle (operands, imm, register addresses).
- `CTRL_W`, default 16: width of the control bundle (ALUOp, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, funct).
- `CTRL_BUBBLE`, default 0: value `ctrl_o` takes whenever no valid entry is presented. Must deassert every write-enable.
- `CLEAR_DATA`, default 0: if 1, `data_o` is zeroed on flush and reset. If 0, `data_o` holds its last value on flush.

- `clk_i` input 1: clock. All state updates on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `start_i` input 1: CPU run enable. When low, no upstream transfer occurs (equivalent to `valid_i`=0).
- `valid_i` input 1: upstream entry valid.
- `ready_o` output 1: block can accept an entry this cycle.
- `ctrl_i` input `CTRL_W`: upstream control bundle.
- `data_i` input `DATA_W`: upstream data bundle.
- `flush_i` input 1: discard all held entries (branch taken or hazard bubble).
- `stall_i` input 1: hazard-unit hold. Blocks the downstream transfer.
- `ready_i` input 1: downstream ready.
- `valid_o` output 1: output entry valid.
- `ctrl_o` output `CTRL_W`: output control bundle.
- `data_o` output `DATA_W`: output data bundle.
- `occupancy_o` output 2: number of held entries, 0 to 2.
- `stall_cnt_o` output 16: saturating count of stalled cycles.
- `bubble_cnt_o` output 16: saturating count of bubble cycles.

## Operation

- Storage: a main entry M drives the outputs; a skid entry S is behind it. Each has a valid bit.
- Transfer conditions:
  - up_xfer = `start_i` & `valid_i` & `ready_o` & !`flush_i`.
  - dn_xfer = `valid_o` & `ready_i` & !`stall_i`.
- `ready_o` = !S.valid. It is a pure register output, with no combinational path from `ready_i`, `stall_i` or `flush_i`.
- `valid_o` = M.valid.
- `ctrl_o` = M.ctrl when M.valid, else `CTRL_BUBBLE`.
- `occupancy_o` = M.valid + S.valid.
- State machine (EMPTY, ONE, FULL), evaluated when !`rst_i` & !`flush_i`:
  - EMPTY: if up_xfer, M <= input and go to ONE; otherwise stay.
  - ONE, up_xfer & dn_xfer: M <= input, stay in ONE.
  - ONE, up_xfer & !dn_xfer: S <= input, go to FULL.
  - ONE, !up_xfer & dn_xfer: go to EMPTY.
  - ONE, neither: hold.
  - FULL: up_xfer is impossible. If dn_xfer, M <= S and go to ONE; otherwise hold.
- Flush (`flush_i`=1, `rst_i`=0):
  - M.valid and S.valid cleared; state becomes EMPTY.
  - An upstream entry offered in the same cycle is dropped.
  - `data_o` is zeroed if `CLEAR_DATA`=1, otherwise held.
  - Counters are not cleared.
- Stall counter: increments when `valid_o` & !dn_xfer & !`flush_i`.
- Bubble counter: increments when !`valid_o` & `start_i`.
- Both counters saturate at 16'hFFFF and never wrap.
- Priority: `rst_i` > `flush_i` > handshake.

## Timing

- Reset (synchronous, takes effect at the edge where `rst_i`=1), values from the next cycle on:
  - `valid_o`=0, `ready_o`=1, `ctrl_o`=`CTRL_BUBBLE`, `data_o`=0, `occupancy_o`=0.
  - `stall_cnt_o`=0, `bubble_cnt_o`=0.
- Reset mid-operation discards both entries irrespective of `flush_i` and `stall_i`.
- Latency: an entry accepted at edge N is on `valid_o`/`ctrl_o`/`data_o` in cycle N+1 (1 cycle).
- Throughput: 1 entry per cycle while downstream accepts.
- Back-pressure: `ready_o` falls one cycle after the first refused dn_xfer with a second entry arriving, i.e. on entering FULL. No entry is lost or duplicated.
- Ordering: strict FIFO, M before S.
- Simultaneous flush and stall: flush wins; outputs show a bubble next cycle.
- Simultaneous dn_xfer and up_xfer in ONE: pass-through; occupancy stays 1.
- Counters update at the same edge as the event and are visible the next cycle.

## Test plan

- Reset then stream: `valid_i`=1 with data 0x1..0x5, `ready_i`=1. Expect `valid_o` from cycle 1, `data_o`=0x1..0x5 in consecutive cycles, `ready_o` constantly 1, `stall_cnt_o`=0.
- Back-pressure: stream 0xA, 0xB, 0xC with `stall_i`=1 for 3 cycles from cycle 1. Expect `occupancy_o` 1→2, `ready_o`=0 while FULL, 0xA held on `data_o`. After release, order is 0xA, 0xB, 0xC with none lost; `stall_cnt_o`=3.
- Flush in FULL with `valid_i`=1 (data 0xD) in the same cycle. Next cycle expect `valid_o`=0, `ctrl_o`=`CTRL_BUBBLE`, `occupancy_o`=0, 0xD never appears.
- `start_i`=0 for 4 cycles with `valid_i`=1. Expect no transfer, `valid_o`=0, `bubble_cnt_o` unchanged. Then `start_i`=1 idle for 2 cycles: `bubble_cnt_o`=2.
- Saturation: force 70000 stalled cycles. Expect `stall_cnt_o`=0xFFFF held, no wrap. A subsequent `rst_i` pulse zeroes the counters one cycle later.
- `CLEAR_DATA`=1 build: flush while `data_o`=0x55. Next cycle `data_o`=0. With `CLEAR_DATA`=0, `data_o` stays 0x55 and `valid_o`=0.
